// File: rtl/count_event_qualifier.sv
// Event qualifier ahead of the up-counter: synchronizer, debounce FSM, rising-edge
// detect and a programmable prescaler producing single-cycle count strobes.
module count_event_qualifier #(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 4,
  parameter int unsigned PrescaleWidth  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     event_i,
  input  logic                     enable,
  input  logic [PrescaleWidth-1:0] prescale,
  output logic                     level_o,
  output logic                     count
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] DbLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] DbOne  = CntW'(1);
  localparam logic [PrescaleWidth-1:0] PcntOne = PrescaleWidth'(1);

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } state_t;

  logic [SyncStages-1:0]    r_sync;
  logic                     w_sync_q;
  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CntW-1:0]          r_db_cnt;
  logic [CntW-1:0]          w_db_cnt_nxt;
  logic                     r_level;
  logic                     w_level_nxt;
  logic                     r_level_q;
  logic                     w_qual;
  logic [PrescaleWidth-1:0] r_pcnt;
  logic                     r_count;

  // Only r_sync[0] ever samples the asynchronous event line.
  always_ff @(posedge clock) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SyncStages-2:0], event_i};
  end

  assign w_sync_q = r_sync[SyncStages-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_LOW;
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_db_cnt  <= w_db_cnt_nxt;
      r_level   <= w_level_nxt;
      r_level_q <= r_level;
    end
  end

  // With DebounceCycles == 1 the stable states switch directly, skipping RISE/FALL.
  always_comb begin
    w_state_nxt  = r_state;
    w_db_cnt_nxt = r_db_cnt;
    w_level_nxt  = r_level;
    case (r_state)
      S_LOW: begin
        if (w_sync_q) begin
          if (DebounceCycles == 1) begin
            w_state_nxt  = S_HIGH;
            w_level_nxt  = 1'b1;
            w_db_cnt_nxt = '0;
          end else begin
            w_state_nxt  = S_RISE;
            w_db_cnt_nxt = DbOne;
          end
        end
      end
      S_RISE: begin
        if (!w_sync_q) begin
          w_state_nxt  = S_LOW;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DbLast) begin
          w_state_nxt  = S_HIGH;
          w_level_nxt  = 1'b1;
          w_db_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DbOne;
        end
      end
      S_HIGH: begin
        if (!w_sync_q) begin
          if (DebounceCycles == 1) begin
            w_state_nxt  = S_LOW;
            w_level_nxt  = 1'b0;
            w_db_cnt_nxt = '0;
          end else begin
            w_state_nxt  = S_FALL;
            w_db_cnt_nxt = DbOne;
          end
        end
      end
      S_FALL: begin
        if (w_sync_q) begin
          w_state_nxt  = S_HIGH;
          w_db_cnt_nxt = '0;
        end else if (r_db_cnt == DbLast) begin
          w_state_nxt  = S_LOW;
          w_level_nxt  = 1'b0;
          w_db_cnt_nxt = '0;
        end else begin
          w_db_cnt_nxt = r_db_cnt + DbOne;
        end
      end
      default: begin
        w_state_nxt  = S_LOW;
        w_level_nxt  = 1'b0;
        w_db_cnt_nxt = '0;
      end
    endcase
  end

  assign w_qual = r_level & ~r_level_q;

  // >= rather than == so a live prescale drop below pcnt strobes on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pcnt  <= '0;
      r_count <= 1'b0;
    end else begin
      r_count <= 1'b0;
      if (enable && w_qual) begin
        if (r_pcnt >= prescale) begin
          r_count <= 1'b1;
          r_pcnt  <= '0;
        end else begin
          r_pcnt <= r_pcnt + PcntOne;
        end
      end
    end
  end

  assign level_o = r_level;
  assign count   = r_count;

endmodule

// File: tb/tb_count_event_qualifier.sv
// Directed bench for count_event_qualifier at default parameters; expected values
// are hand-derived edge counts relative to the first sampling edge of event_i.
module tb_count_event_qualifier;

  logic       clock = 1'b0;
  logic       reset;
  logic       event_i;
  logic       enable;
  logic [7:0] prescale;
  logic       level_o;
  logic       count;

  int   vectors     = 0;
  int   miscompares = 0;
  int   strobes     = 0;
  int   wide        = 0;
  logic prev_count  = 1'b0;
  logic level_seen  = 1'b0;
  logic e5_level;
  logic e6_count;

  always #5 clock = ~clock;

  count_event_qualifier #(
    .SyncStages    (2),
    .DebounceCycles(4),
    .PrescaleWidth (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .event_i (event_i),
    .enable  (enable),
    .prescale(prescale),
    .level_o (level_o),
    .count   (count)
  );

  always @(negedge clock) begin
    if (count === 1'b1) begin
      strobes++;
      if (prev_count === 1'b1) wide++;
    end
    if (level_o === 1'b1) level_seen = 1'b1;
    prev_count = count;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Clean pulse: after 6 ticks we sit just past E5, after 7 just past E6.
  task automatic pulse(input int high, input int low);
    event_i = 1'b1;
    repeat (6) tick();
    e5_level = level_o;
    tick();
    e6_count = count;
    repeat (high - 7) tick();
    event_i = 1'b0;
    repeat (low) tick();
  endtask

  initial begin
    reset    = 1'b1;
    event_i  = 1'b0;
    enable   = 1'b1;
    prescale = 8'd0;
    repeat (3) tick();
    chk("reset_level", 32'(level_o), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_level", 32'(level_o), 32'd0);

    // Single clean edge, prescale 0
    strobes = 0;
    event_i = 1'b1;
    repeat (5) tick();
    chk("t1_e4_level", 32'(level_o), 32'd0);
    tick();
    chk("t1_e5_level", 32'(level_o), 32'd1);
    chk("t1_e5_count", 32'(count), 32'd0);
    tick();
    chk("t1_e6_count", 32'(count), 32'd1);
    tick();
    chk("t1_e7_count", 32'(count), 32'd0);
    repeat (12) tick();
    chk("t1_level_held", 32'(level_o), 32'd1);
    event_i = 1'b0;
    repeat (12) tick();
    chk("t1_level_fall", 32'(level_o), 32'd0);
    chk("t1_strobes", 32'(strobes), 32'd1);

    // Glitches of 3 cycles are one short of the debounce window
    strobes    = 0;
    level_seen = 1'b0;
    repeat (5) begin
      event_i = 1'b1;
      repeat (3) tick();
      event_i = 1'b0;
      repeat (5) tick();
      chk("t2_level", 32'(level_o), 32'd0);
    end
    chk("t2_level_seen", 32'(level_seen), 32'd0);
    chk("t2_strobes", 32'(strobes), 32'd0);

    // Prescale 2: strobe on qualified edges 3 and 6
    prescale = 8'd2;
    strobes  = 0;
    for (int i = 1; i <= 6; i++) begin
      pulse(10, 10);
      chk($sformatf("t3_pulse%0d_e6", i), 32'(e6_count), 32'((i % 3) == 0));
    end
    chk("t3_strobes", 32'(strobes), 32'd2);

    // Disabled edges are ignored while debounce keeps running
    enable  = 1'b0;
    strobes = 0;
    repeat (2) begin
      pulse(10, 10);
      chk("t4_dis_level", 32'(e5_level), 32'd1);
    end
    chk("t4_dis_strobes", 32'(strobes), 32'd0);
    enable   = 1'b1;
    prescale = 8'd1;
    pulse(10, 10);
    chk("t4_en1_e6", 32'(e6_count), 32'd0);
    pulse(10, 10);
    chk("t4_en2_e6", 32'(e6_count), 32'd1);
    chk("t4_strobes", 32'(strobes), 32'd1);

    // Reset mid-debounce with event held high restarts full latency
    prescale = 8'd0;
    strobes  = 0;
    event_i  = 1'b1;
    repeat (5) tick();
    chk("t5_pre_level", 32'(level_o), 32'd0);
    reset = 1'b1;
    tick();
    chk("t5_rst_level", 32'(level_o), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    chk("t5_e4_level", 32'(level_o), 32'd0);
    tick();
    chk("t5_e5_level", 32'(level_o), 32'd1);
    tick();
    chk("t5_e6_count", 32'(count), 32'd1);
    repeat (10) tick();
    event_i = 1'b0;
    repeat (10) tick();
    chk("t5_strobes", 32'(strobes), 32'd1);

    // Live prescale decrease below pcnt
    prescale = 8'd5;
    strobes  = 0;
    repeat (3) begin
      pulse(10, 10);
      chk("t6_climb_e6", 32'(e6_count), 32'd0);
    end
    prescale = 8'd1;
    pulse(10, 10);
    chk("t6_shrink_e6", 32'(e6_count), 32'd1);
    pulse(10, 10);
    chk("t6_after0_e6", 32'(e6_count), 32'd0);
    pulse(10, 10);
    chk("t6_after1_e6", 32'(e6_count), 32'd1);
    chk("t6_strobes", 32'(strobes), 32'd2);

    chk("strobe_width", 32'(wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
